// File: rtl/run_controller.sv
// Run sequencer for an attached processor: holds it in reset, lets it run until it
// reports done or a cycle limit expires, then reports the outcome for one cycle.
module run_controller #(
   parameter int CW      = 16,
   parameter int RST_CYC = 2,
   parameter int TIMEOUT = 4095
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          core_done,
   output logic          core_reset,
   output logic          core_req,
   output logic          busy,
   output logic          result_valid,
   output logic [1:0]    status,
   output logic [CW-1:0] cycles
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RST  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0]    RST_LOAD   = 4'(RST_CYC - 1);
   localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] TO_VALUE   = CW'(TIMEOUT);
   localparam logic [1:0]    ST_NONE    = 2'b00;
   localparam logic [1:0]    ST_DONE    = 2'b01;
   localparam logic [1:0]    ST_TIMEOUT = 2'b10;

   state_t        r_state;
   logic [3:0]    r_rst_cnt;
   logic [CW-1:0] r_cycles;
   logic [1:0]    r_status;
   logic          r_core_reset;
   logic          r_core_req;
   logic          r_busy;
   logic          r_result_valid;

   // Outputs are registered alongside each transition so they match the entered state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_rst_cnt      <= '0;
         r_cycles       <= '0;
         r_status       <= ST_NONE;
         r_core_reset   <= 1'b1;
         r_core_req     <= 1'b0;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state      <= S_RST;
                  r_rst_cnt    <= RST_LOAD;
                  r_cycles     <= '0;
                  r_status     <= ST_NONE;
                  r_busy       <= 1'b1;
               end
            end
            S_RST: begin
               if (r_rst_cnt == 4'd0) begin
                  r_state      <= S_RUN;
                  r_core_reset <= 1'b0;
                  r_core_req   <= 1'b1;
               end else begin
                  r_rst_cnt    <= r_rst_cnt - 4'd1;
               end
            end
            S_RUN: begin
               // Completion takes precedence over the cycle limit on the same edge.
               if (core_done) begin
                  r_state        <= S_DONE;
                  r_status       <= ST_DONE;
                  r_core_req     <= 1'b0;
                  r_result_valid <= 1'b1;
               end else if (r_cycles == TO_LAST) begin
                  r_state        <= S_DONE;
                  r_cycles       <= TO_VALUE;
                  r_status       <= ST_TIMEOUT;
                  r_core_req     <= 1'b0;
                  r_result_valid <= 1'b1;
               end else begin
                  r_cycles       <= r_cycles + 1'b1;
               end
            end
            S_DONE: begin
               r_state        <= S_IDLE;
               r_core_reset   <= 1'b1;
               r_busy         <= 1'b0;
               r_result_valid <= 1'b0;
            end
            default: begin
               r_state        <= S_IDLE;
               r_core_reset   <= 1'b1;
               r_core_req     <= 1'b0;
               r_busy         <= 1'b0;
               r_result_valid <= 1'b0;
            end
         endcase
      end
   end

   assign core_reset   = r_core_reset;
   assign core_req     = r_core_req;
   assign busy         = r_busy;
   assign result_valid = r_result_valid;
   assign status       = r_status;
   assign cycles       = r_cycles;

endmodule
